// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and unified-memory handshakes around mem_port_arbiter.
// slave is the arbiter's view; master is the core/memory-model view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              stale;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              bus_err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, dm_rdata, dm_done, stale,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, dm_rdata, dm_done, stale,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is DM-priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, ERR} state_t;

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_inc;
  logic              if_act, dm_act, dm_wins_tie;
  logic              grant_dm, grant_if, complete, timeout_hit;

  logic              mem_req_q, mem_we_q, bus_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              if_valid_q, dm_done_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef MEM_ARB_RR_EN
  logic last_dm_q;  // 1 = DM won the most recent grant
  assign dm_wins_tie = ~last_dm_q;
`else
  assign dm_wins_tie = 1'b1;
`endif

  always_comb begin
    // A requester's own completion cycle masks its still-held request
    if_act      = bus.if_req & ~if_valid_q;
    dm_act      = bus.dm_req & ~dm_done_q;
    state_nxt   = state_q;
    grant_dm    = 1'b0;
    grant_if    = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    cnt_inc     = sat_inc(cnt_q);
    case (state_q)
      IDLE: begin
        if (dm_act && (!if_act || dm_wins_tie)) begin
          grant_dm  = 1'b1;
          state_nxt = DM_BUSY;
        end else if (if_act) begin
          grant_if  = 1'b1;
          state_nxt = IF_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (bus.mem_ready) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (TIMEOUT != 0 && cnt_inc == CNT_W'(TIMEOUT)) begin
          timeout_hit = 1'b1;
          state_nxt   = ERR;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_done_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
`ifdef MEM_ARB_RR_EN
      last_dm_q   <= 1'b0;
`endif
    end else begin
      if_valid_q <= 1'b0;
      dm_done_q  <= 1'b0;
      if (grant_dm || grant_if) begin
        mem_req_q  <= 1'b1;
        mem_we_q   <= grant_dm & bus.dm_we;
        mem_addr_q <= grant_dm ? bus.dm_addr : bus.if_addr;
        if (grant_dm) mem_wdata_q <= bus.dm_wdata;
        cnt_q      <= '0;
`ifdef MEM_ARB_RR_EN
        last_dm_q  <= grant_dm;
`endif
      end else if (complete) begin
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
        if (state_q == DM_BUSY) begin
          dm_rdata_q <= bus.mem_rdata;
          dm_done_q  <= 1'b1;
        end else begin
          if_rdata_q <= bus.mem_rdata;
          if_valid_q <= 1'b1;
        end
      end else if (timeout_hit) begin
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
        bus_err_q <= 1'b1;
        cnt_q     <= cnt_inc;
      end else if (state_q == IF_BUSY || state_q == DM_BUSY) begin
        cnt_q <= cnt_inc;
      end
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.stale     = (bus.dm_req & ~dm_done_q) | (bus.if_req & ~if_valid_q) | bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: queued expectations for memory-side
// transactions and for fetch/load completions, checked as the DUT produces them.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mem_txn_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          n_vec  = 0;
  int          n_miss = 0;
  mem_txn_t    mem_q[$];
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  bit          tb_last_dm = 1'b0;
  bit          resp_en    = 1'b0;
  int          mem_lat    = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_for(input logic [31:0] addr);
    if (addr == 32'h10) return 32'h0050_0093;
    return {addr[15:0], 16'hC0DE} ^ 32'h1234_0000;
  endfunction

  // Memory model: raises mem_ready mem_lat cycles after seeing mem_req
  initial begin
    int wcnt = 0;
    forever begin
      @(negedge clk);
      if (!resp_en || !rst_n) begin
        wcnt = 0;
      end else if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        wcnt = 0;
      end else if (bus.mem_req) begin
        if (wcnt == mem_lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = data_for(bus.mem_addr);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    logic prev_req = 1'b0;
    mem_txn_t t;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !prev_req) begin
        if (mem_q.size() == 0) begin
          check_val("mem_unexpected", 32'(mem_q.size()), 1);
        end else begin
          t = mem_q.pop_front();
          check_val("mem_addr", bus.mem_addr, t.addr);
          check_val("mem_we", 32'(bus.mem_we), 32'(t.we));
          if (t.we) check_val("mem_wdata", bus.mem_wdata, t.wdata);
        end
      end
      prev_req = bus.mem_req;
      if (bus.if_valid) begin
        if (if_q.size() == 0) check_val("if_unexpected", 32'(bus.if_valid), 0);
        else                  check_val("if_rdata", bus.if_rdata, if_q.pop_front());
      end
      if (bus.dm_done) begin
        if (dm_q.size() == 0) check_val("dm_unexpected", 32'(bus.dm_done), 0);
        else                  check_val("dm_rdata", bus.dm_rdata, dm_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_if(input logic [31:0] addr, input bit solo);
    bit got = 1'b0;
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    #1 check_val("if_stale_on", 32'(bus.stale), 1);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (i == 0 && solo) check_val("if_grant_lat", 32'(bus.mem_req), 1);
      if (bus.if_valid) got = 1'b1;
    end
    check_val("if_wait", 32'(got), 1);
    bus.if_req = 1'b0;
    #1 if (solo) check_val("if_stale_off", 32'(bus.stale), 0);
    @(negedge clk);
    check_val("if_pulse_w", 32'(bus.if_valid), 0);
  endtask

  task automatic do_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit solo);
    bit got = 1'b0;
    @(negedge clk);
    bus.dm_req   = 1'b1;
    bus.dm_we    = we;
    bus.dm_addr  = addr;
    bus.dm_wdata = wdata;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (i == 0 && solo) check_val("dm_grant_lat", 32'(bus.mem_req), 1);
      if (bus.dm_done) got = 1'b1;
      else if (solo)   check_val("dm_stale_hold", 32'(bus.stale), 1);
    end
    check_val("dm_wait", 32'(got), 1);
    bus.dm_req = 1'b0;
    #1 if (solo) check_val("dm_stale_off", 32'(bus.stale), 0);
    @(negedge clk);
    check_val("dm_pulse_w", 32'(bus.dm_done), 0);
  endtask

  task automatic t_if(input logic [31:0] addr);
    mem_q.push_back('{addr: addr, we: 1'b0, wdata: 32'h0});
    if_q.push_back(data_for(addr));
    tb_last_dm = 1'b0;
    do_if(addr, 1'b1);
  endtask

  task automatic t_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    mem_q.push_back('{addr: addr, we: we, wdata: wdata});
    dm_q.push_back(data_for(addr));
    tb_last_dm = 1'b1;
    do_dm(we, addr, wdata, 1'b1);
  endtask

  task automatic t_tie(input logic [31:0] a_dm, input logic [31:0] a_if);
    bit dm_first;
    dm_first = RR ? !tb_last_dm : 1'b1;
    if (dm_first) begin
      mem_q.push_back('{addr: a_dm, we: 1'b0, wdata: 32'h0});
      mem_q.push_back('{addr: a_if, we: 1'b0, wdata: 32'h0});
    end else begin
      mem_q.push_back('{addr: a_if, we: 1'b0, wdata: 32'h0});
      mem_q.push_back('{addr: a_dm, we: 1'b0, wdata: 32'h0});
    end
    tb_last_dm = !dm_first;
    dm_q.push_back(data_for(a_dm));
    if_q.push_back(data_for(a_if));
    fork
      do_dm(1'b0, a_dm, 32'h0, 1'b0);
      do_if(a_if, 1'b0);
    join
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tb_last_dm = 1'b0;
    #1;
  endtask

  initial begin
    int busy_cnt;
    rst_n         = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_mem_req", 32'(bus.mem_req), 0);
    check_val("rst_mem_addr", bus.mem_addr, 0);
    check_val("rst_if_valid", 32'(bus.if_valid), 0);
    check_val("rst_dm_done", 32'(bus.dm_done), 0);
    check_val("rst_bus_err", 32'(bus.bus_err), 0);
    check_val("rst_stale", 32'(bus.stale), 0);
    rst_n   = 1'b1;
    resp_en = 1'b1;

    // Fetch with two-cycle memory latency, then a store
    mem_lat = 2;
    t_if(32'h10);
    t_dm(1'b1, 32'h100, 32'hDEAD_BEEF);

    // Simultaneous requests, twice
    mem_lat = 1;
    t_tie(32'h200, 32'h20);
    t_tie(32'h204, 32'h24);

    // Timeout: memory never answers
    resp_en = 1'b0;
    bus.mem_ready = 1'b0;
    mem_q.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0});
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.bus_err) break;
      if (bus.mem_req) busy_cnt++;
    end
    check_val("to_busy_cycles", 32'(busy_cnt), 15);
    check_val("to_bus_err", 32'(bus.bus_err), 1);
    check_val("to_mem_req", 32'(bus.mem_req), 0);
    check_val("to_stale", 32'(bus.stale), 1);
    bus.if_req  = 1'b0;
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h304;
    repeat (4) @(negedge clk);
    check_val("err_no_grant", 32'(bus.mem_req), 0);
    check_val("err_stale_sticky", 32'(bus.stale), 1);
    bus.dm_req = 1'b0;
    enter_reset();
    check_val("err_rst_bus_err", 32'(bus.bus_err), 0);
    check_val("err_rst_mem_req", 32'(bus.mem_req), 0);
    check_val("err_rst_stale", 32'(bus.stale), 0);
    check_val("err_rst_if_rdata", bus.if_rdata, 0);
    check_val("err_rst_dm_rdata", bus.dm_rdata, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    resp_en = 1'b1;

    // First tie after reset goes to DM in both arbitration modes
    t_tie(32'h208, 32'h28);

    // Reset in the middle of a DM transaction
    resp_en = 1'b0;
    mem_q.push_back('{addr: 32'h400, we: 1'b1, wdata: 32'h1234_5678});
    @(negedge clk);
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h400;
    bus.dm_wdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    check_val("mid_mem_req", 32'(bus.mem_req), 1);
    enter_reset();
    check_val("mid_rst_mem_req", 32'(bus.mem_req), 0);
    bus.dm_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("mid_no_done", 32'(bus.dm_done), 0);

    // mem_ready while idle must be ignored
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    repeat (2) @(negedge clk);
    check_val("idle_rdy_mem_req", 32'(bus.mem_req), 0);
    check_val("idle_rdy_if_valid", 32'(bus.if_valid), 0);
    check_val("idle_rdy_dm_done", 32'(bus.dm_done), 0);
    check_val("idle_rdy_if_rdata", bus.if_rdata, 0);
    bus.mem_ready = 1'b0;
    resp_en = 1'b1;

    // Normal traffic afterwards; read data registers hold between completions
    mem_lat = 0;
    t_if(32'h44);
    check_val("dm_rdata_hold", bus.dm_rdata, 0);
    mem_lat = 3;
    t_dm(1'b0, 32'h48, 32'h0);
    check_val("if_rdata_hold", bus.if_rdata, data_for(32'h44));

    repeat (3) @(negedge clk);
    check_val("mem_q_drained", 32'(mem_q.size()), 0);
    check_val("if_q_drained", 32'(if_q.size()), 0);
    check_val("dm_q_drained", 32'(dm_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
